// File: rtl/matr_valida.sv
// ---------------------------------------------------------------------------
// matr_valida -- licence-plate whitelist validation stage.
//
// A plate strobed in by the reader is captured and compared against a small
// programmable whitelist, one entry per clock. A hit raises a one-cycle
// MatrVal strobe with the plate and the barrier open time (Q6) for the
// downstream barrier-timing stage. Then the block holds off new plates for
// OPEN_CYCLES cycles so that two vehicles never share one opening. A miss
// raises a one-cycle Denied strobe.
//
// Optional feature (compile-time macro):
//   MATR_ANTIPASSBACK_EN - remember the last granted plate. A hit on that same
//                          plate is denied instead of granted.
//
// Parameters:
//   N_ENTRIES   - whitelist depth (power of two, 2..16)
//   OPEN_CYCLES - open time driven on Q6 at grant, and hold-off length
//
// Ports:
//   CLK, RST    - clock; synchronous active-high reset
//   Plate_in    - 24-bit plate from the reader
//   Plate_valid - single-cycle strobe qualifying Plate_in
//   Prog_en     - whitelist write strobe (honoured only while idle)
//   Prog_addr   - whitelist entry index
//   Prog_data   - plate to store; zero clears the entry
//   MatrVal     - one-cycle grant strobe
//   Matricula   - last granted plate, held until the next grant
//   Q6          - open time for the barrier stage, loaded at grant
//   Denied      - one-cycle miss strobe
//   Busy        - high whenever the block is not idle
//   Overrun     - one-cycle pulse when a Plate_valid is dropped
// ---------------------------------------------------------------------------
module matr_valida #(
  parameter int         N_ENTRIES   = 8,
  parameter logic [6:0] OPEN_CYCLES = 7'd20
) (
  input  logic                         CLK,
  input  logic                         RST,
  input  logic [23:0]                  Plate_in,
  input  logic                         Plate_valid,
  input  logic                         Prog_en,
  input  logic [$clog2(N_ENTRIES)-1:0] Prog_addr,
  input  logic [23:0]                  Prog_data,
  output logic                         MatrVal,
  output logic [23:0]                  Matricula,
  output logic [6:0]                   Q6,
  output logic                         Denied,
  output logic                         Busy,
  output logic                         Overrun
);

  localparam int            AW       = $clog2(N_ENTRIES);
  localparam logic [AW-1:0] LAST_IDX = AW'(N_ENTRIES - 1);

  typedef enum logic [2:0] {
    IDLE,
    SEARCH,
    GRANT,
    DENY,
    HOLD
  } state_t;

  state_t               state;
  logic [AW-1:0]        idx;
  logic [6:0]           hold_cnt;
  logic [23:0]          work;
  logic [N_ENTRIES-1:0] tbl_vld;
  logic [23:0]          tbl_plate [N_ENTRIES];
  logic                 hit;
  logic                 repeat_hit;

  // An invalid entry never matches, and neither does the all-zero plate.
  function automatic logic plate_match(input logic        entry_vld,
                                       input logic [23:0] entry,
                                       input logic [23:0] plate);
    return entry_vld && (plate != 24'h0) && (entry == plate);
  endfunction

  assign hit = plate_match(tbl_vld[idx], tbl_plate[idx], work);

`ifdef MATR_ANTIPASSBACK_EN
  logic [23:0] last_grant;
  // last_grant resets to zero, and a zero plate can never hit, so a freshly
  // reset block never blocks its first vehicle.
  assign repeat_hit = (work == last_grant);
`else
  assign repeat_hit = 1'b0;
`endif

  // Plate storage and the working plate register carry data only. Their
  // validity is tracked by tbl_vld and by the FSM, so they need no reset.
  always_ff @(posedge CLK) begin
    if (state == IDLE) begin
      if (Prog_en) begin
        tbl_plate[Prog_addr] <= Prog_data;
      end else if (Plate_valid) begin
        work <= Plate_in;
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= IDLE;
      idx       <= '0;
      hold_cnt  <= '0;
      tbl_vld   <= '0;
      MatrVal   <= 1'b0;
      Denied    <= 1'b0;
      Overrun   <= 1'b0;
      Busy      <= 1'b0;
      Matricula <= '0;
      Q6        <= '0;
`ifdef MATR_ANTIPASSBACK_EN
      last_grant <= '0;
`endif
    end else begin
      MatrVal <= 1'b0;
      Denied  <= 1'b0;
      // A plate that arrives while the block is busy is dropped. The IDLE
      // branch below overrides this for the write-versus-plate collision.
      Overrun <= (state != IDLE) && Plate_valid;

      case (state)
        IDLE: begin
          if (Prog_en) begin
            // The write takes priority. A plate arriving in the same cycle is lost.
            tbl_vld[Prog_addr] <= (Prog_data != 24'h0);
            if (Plate_valid) begin
              Overrun <= 1'b1;
            end
          end else if (Plate_valid) begin
            idx   <= '0;
            state <= SEARCH;
            Busy  <= 1'b1;
          end
        end

        SEARCH: begin
          if (hit && !repeat_hit) begin
            state     <= GRANT;
            MatrVal   <= 1'b1;
            Matricula <= work;
            Q6        <= OPEN_CYCLES;
`ifdef MATR_ANTIPASSBACK_EN
            last_grant <= work;
`endif
          end else if (hit || (idx == LAST_IDX)) begin
            state  <= DENY;
            Denied <= 1'b1;
          end else begin
            idx <= idx + AW'(1);
          end
        end

        GRANT: begin
          state    <= HOLD;
          hold_cnt <= OPEN_CYCLES;
        end

        DENY: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end

        HOLD: begin
          // The counter is loaded with OPEN_CYCLES on entry. HOLD is left on
          // the cycle the count is 1, so HOLD spans exactly OPEN_CYCLES cycles.
          if (hold_cnt <= 7'd1) begin
            state    <= IDLE;
            hold_cnt <= '0;
            Busy     <= 1'b0;
          end else begin
            hold_cnt <= hold_cnt - 7'd1;
          end
        end

        default: begin
          state <= IDLE;
          Busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_matr_valida.sv
// ---------------------------------------------------------------------------
// tb_matr_valida -- self-checking bench for matr_valida.
// Directed vector table of searches, hand-written corner sequences (hold-off
// overrun, write/plate collision, reset mid-search and mid-hold), then a
// randomized run against a transaction-level reference model.
// ---------------------------------------------------------------------------
module tb_matr_valida;

  localparam int         N    = 8;
  localparam logic [6:0] OPEN = 7'd20;
`ifdef MATR_ANTIPASSBACK_EN
  localparam bit APB = 1'b1;
`else
  localparam bit APB = 1'b0;
`endif

  logic        CLK = 1'b0;
  logic        RST;
  logic [23:0] Plate_in;
  logic        Plate_valid;
  logic        Prog_en;
  logic [2:0]  Prog_addr;
  logic [23:0] Prog_data;
  logic        MatrVal;
  logic [23:0] Matricula;
  logic [6:0]  Q6;
  logic        Denied;
  logic        Busy;
  logic        Overrun;

  always #5 CLK = ~CLK;

  matr_valida #(
    .N_ENTRIES   (N),
    .OPEN_CYCLES (OPEN)
  ) dut (
    .CLK         (CLK),
    .RST         (RST),
    .Plate_in    (Plate_in),
    .Plate_valid (Plate_valid),
    .Prog_en     (Prog_en),
    .Prog_addr   (Prog_addr),
    .Prog_data   (Prog_data),
    .MatrVal     (MatrVal),
    .Matricula   (Matricula),
    .Q6          (Q6),
    .Denied      (Denied),
    .Busy        (Busy),
    .Overrun     (Overrun)
  );

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [23:0] mat_exp;
  logic [6:0]  q6_exp;

  typedef struct {
    logic [23:0] plate;
    bit          grant;
    int          ev_n;    // cycles after the strobe cycle until MatrVal/Denied
    int          free_n;  // cycles after the strobe cycle until Busy drops
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  function automatic vec_t v_hit(input logic [23:0] p, input int k);
    vec_t v;
    v = '{plate: p, grant: 1'b1, ev_n: k + 2, free_n: k + 3 + int'(OPEN)};
    return v;
  endfunction

  function automatic vec_t v_miss(input logic [23:0] p);
    vec_t v;
    v = '{plate: p, grant: 1'b0, ev_n: N + 1, free_n: N + 2};
    return v;
  endfunction

  // Repeat of the previously granted plate. With anti-passback it is denied
  // at the cycle the grant would have come.
  function automatic vec_t v_rep(input logic [23:0] p, input int k);
    vec_t v;
    if (APB) v = '{plate: p, grant: 1'b0, ev_n: k + 2, free_n: k + 3};
    else     v = v_hit(p, k);
    return v;
  endfunction

  task automatic do_reset();
    RST = 1'b1; Plate_valid = 1'b0; Prog_en = 1'b0;
    tick();
    tick();
    RST = 1'b0;
    mat_exp = '0;
    q6_exp  = '0;
  endtask

  task automatic prog(input int a, input logic [23:0] d);
    Prog_en = 1'b1; Prog_addr = 3'(a); Prog_data = d;
    tick();
    Prog_en = 1'b0;
  endtask

  task automatic check_reset_outs(input string name);
    check({name, "_matrval"},   MatrVal,   0);
    check({name, "_denied"},    Denied,    0);
    check({name, "_overrun"},   Overrun,   0);
    check({name, "_busy"},      Busy,      0);
    check({name, "_matricula"}, Matricula, 0);
    check({name, "_q6"},        Q6,        0);
  endtask

  task automatic check_search(input string name, input vec_t v);
    int          ev_n, free_n, strobes;
    bit          ev_g;
    logic [23:0] mat_at;
    logic [6:0]  q6_at;
    ev_n = -1; free_n = -1; strobes = 0; ev_g = 1'b0;
    mat_at = Matricula; q6_at = Q6;
    Plate_in = v.plate; Plate_valid = 1'b1;
    tick();
    Plate_valid = 1'b0; Plate_in = '0;
    check({name, "_busy_start"}, Busy, 1);
    for (int n = 1; n <= 200; n++) begin
      if (MatrVal || Denied) begin
        strobes++;
        if (ev_n < 0) begin
          ev_n = n; ev_g = MatrVal; mat_at = Matricula; q6_at = Q6;
        end
      end
      if (!Busy) begin
        free_n = n;
        break;
      end
      tick();
    end
    if (v.grant) begin
      mat_exp = v.plate;
      q6_exp  = OPEN;
    end
    check({name, "_granted"},   32'(ev_g), 32'(v.grant));
    check({name, "_ev_cycle"},  ev_n,      v.ev_n);
    check({name, "_idle_cyc"},  free_n,    v.free_n);
    check({name, "_strobes"},   strobes,   1);
    check({name, "_matricula"}, mat_at,    mat_exp);
    check({name, "_q6"},        q6_at,     q6_exp);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int strobes, free;
    logic [23:0] pool [6];
    // reference model state for the randomized run
    bit          tv [N];
    logic [23:0] tp [N];
    int          grant_cyc, deny_cyc, ovr_cyc, busy_from, free_at;
    logic [23:0] pend_mat, m_mat, last;
    logic [6:0]  m_q6;

    RST = 1'b1; Plate_in = '0; Plate_valid = 1'b0;
    Prog_en = 1'b0; Prog_addr = '0; Prog_data = '0;

    // ---------------- reset and directed vector table ----------------
    do_reset();
    check_reset_outs("reset");
    check_search("empty_miss", v_miss(24'h111111));

    prog(3, 24'hABC123);
    prog(0, 24'h000111);
    prog(5, 24'h555555);
    prog(7, 24'h777777);

    vecs.push_back(v_hit (24'hABC123, 3));
    vecs.push_back(v_miss(24'h111111));
    vecs.push_back(v_hit (24'h000111, 0));
    vecs.push_back(v_hit (24'h777777, 7));
    vecs.push_back(v_hit (24'hABC123, 3));
    vecs.push_back(v_rep (24'hABC123, 3));
    vecs.push_back(v_miss(24'h000000));
    vecs.push_back(v_hit (24'h555555, 5));
    vecs.push_back(v_miss(24'h222222));
    vecs.push_back(v_hit (24'hABC123, 3));
    for (int i = 0; i < vecs.size(); i++) begin
      check_search($sformatf("vec%0d", i), vecs[i]);
    end

    // ---------------- plate and write during HOLD ----------------
    do_reset();
    prog(2, 24'h2A2A2A);
    Plate_in = 24'h2A2A2A; Plate_valid = 1'b1;
    tick();                                   // n=1
    Plate_valid = 1'b0;
    tick(); tick(); tick();                   // n=4
    check("A_grant", MatrVal, 1);
    check("A_matricula", Matricula, 24'h2A2A2A);
    mat_exp = 24'h2A2A2A; q6_exp = OPEN;
    tick();                                   // n=5, HOLD
    Plate_valid = 1'b1;
    tick();                                   // n=6
    Plate_valid = 1'b0;
    check("A_overrun", Overrun, 1);
    check("A_busy_hold", Busy, 1);
    Prog_en = 1'b1; Prog_addr = 3'd2; Prog_data = 24'h999999;
    tick();                                   // n=7
    Prog_en = 1'b0;
    check("A_prog_no_overrun", Overrun, 0);
    strobes = 0; free = -1;
    for (int n = 7; n <= 60; n++) begin
      if (MatrVal || Denied) strobes++;
      if (!Busy) begin
        free = n;
        break;
      end
      tick();
    end
    check("A_no_second_strobe", strobes, 0);
    check("A_idle_cycle", free, 5 + int'(OPEN));
    check_search("A_prog_ignored_miss", v_miss(24'h999999));
    check_search("A_entry_kept", v_rep(24'h2A2A2A, 2));

    // ---------------- write and plate in the same idle cycle ----------------
    Prog_en = 1'b1; Prog_addr = 3'd4; Prog_data = 24'h444444;
    Plate_valid = 1'b1; Plate_in = 24'h444444;
    tick();
    Prog_en = 1'b0; Plate_valid = 1'b0;
    check("B_overrun", Overrun, 1);
    check("B_no_search", Busy, 0);
    tick();
    check("B_overrun_pulse", Overrun, 0);
    check("B_no_grant", MatrVal, 0);
    check_search("B_written", v_hit(24'h444444, 4));
    prog(4, 24'h0);
    check_search("B_cleared", v_miss(24'h444444));

    // ---------------- reset during SEARCH ----------------
    do_reset();
    prog(1, 24'h121212);
    prog(7, 24'h777777);
    check_search("C_grant", v_hit(24'h121212, 1));
    Plate_in = 24'h777777; Plate_valid = 1'b1;
    tick();
    Plate_valid = 1'b0;
    tick(); tick();                           // mid-search
    RST = 1'b1;
    tick();
    RST = 1'b0;
    mat_exp = '0; q6_exp = '0;
    check_reset_outs("C_rst_search");
    strobes = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (MatrVal || Denied || Busy) strobes++;
    end
    check("C_quiet", strobes, 0);
    check_search("C_table_cleared", v_miss(24'h121212));

    // ---------------- reset during HOLD ----------------
    prog(0, 24'h0A0A0A);
    Plate_in = 24'h0A0A0A; Plate_valid = 1'b1;
    tick();
    Plate_valid = 1'b0;
    tick();                                   // n=2
    check("D_grant", MatrVal, 1);
    for (int i = 0; i < 5; i++) tick();       // in HOLD
    RST = 1'b1;
    tick();
    RST = 1'b0;
    mat_exp = '0; q6_exp = '0;
    check_reset_outs("D_rst_hold");
    strobes = 0;
    for (int i = 0; i < 25; i++) begin
      tick();
      if (MatrVal || Denied || Busy) strobes++;
    end
    check("D_quiet", strobes, 0);
    check_search("D_table_cleared", v_miss(24'h0A0A0A));

    // ---------------- randomized run vs reference model ----------------
    pool[0] = 24'h000000; pool[1] = 24'h100001; pool[2] = 24'h200002;
    pool[3] = 24'h300003; pool[4] = 24'h400004; pool[5] = 24'h500005;
    do_reset();
    for (int i = 0; i < N; i++) begin
      tv[i] = 1'b0; tp[i] = '0;
    end
    grant_cyc = -1; deny_cyc = -1; ovr_cyc = -1; busy_from = 0; free_at = 0;
    pend_mat = '0; m_mat = '0; last = '0; m_q6 = '0;

    for (int c = 0; c < 4000; c++) begin
      bit          pv, pe;
      int          a, hk;
      logic [23:0] pd, pl;

      if (c == grant_cyc) begin
        m_mat = pend_mat;
        m_q6  = OPEN;
      end
      check("rnd_matrval",   MatrVal,   32'(c == grant_cyc));
      check("rnd_denied",    Denied,    32'(c == deny_cyc));
      check("rnd_overrun",   Overrun,   32'(c == ovr_cyc));
      check("rnd_busy",      Busy,      32'((c >= busy_from) && (c < free_at)));
      check("rnd_matricula", Matricula, m_mat);
      check("rnd_q6",        Q6,        m_q6);

      pv = ($urandom_range(0, 5) == 0);
      pe = ($urandom_range(0, 9) == 0);
      a  = $urandom_range(0, N - 1);
      pd = pool[$urandom_range(0, 5)];
      pl = pool[$urandom_range(0, 5)];

      if (c >= free_at) begin
        if (pe) begin
          tv[a] = (pd != 24'h0);
          tp[a] = pd;
          if (pv) ovr_cyc = c + 1;
        end else if (pv) begin
          busy_from = c + 1;
          hk = -1;
          for (int k = 0; k < N; k++) begin
            if (hk < 0 && tv[k] && pl != 24'h0 && tp[k] == pl) hk = k;
          end
          if (hk < 0) begin
            deny_cyc = c + 1 + N;
            free_at  = deny_cyc + 1;
          end else if (APB && pl == last) begin
            deny_cyc = c + 2 + hk;
            free_at  = deny_cyc + 1;
          end else begin
            grant_cyc = c + 2 + hk;
            pend_mat  = pl;
            last      = pl;
            free_at   = grant_cyc + int'(OPEN) + 1;
          end
        end
      end else if (pv) begin
        ovr_cyc = c + 1;
      end

      Plate_valid = pv; Plate_in = pl;
      Prog_en = pe; Prog_addr = 3'(a); Prog_data = pd;
      tick();
    end
    Plate_valid = 1'b0; Prog_en = 1'b0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/matr_valida.md
# matr_valida

Plate-validation stage directly upstream of the barrier-timing block. Accepts a 24-bit licence plate (Matricula) from the reader, searches a small programmable whitelist one entry per clock, and on a hit issues a one-cycle MatrVal strobe together with the plate and the barrier open time Q6 for the barrier stage to consume. Misses produce a Denied pulse. After a grant, the block holds off new plates for the barrier open window so two vehicles are never granted into one opening.

## Interface
- N_ENTRIES, 8 — whitelist depth; power of two, 2..16.
- OPEN_CYCLES, 7'd20 — value driven on Q6 at grant; also the hold-off length; 1..127.

- CLK  in  1  system clock, all logic on rising edge.
- RST  in  1  synchronous, active-high reset.
- Plate_in  in  24  plate from reader.
- Plate_valid  in  1  single-cycle strobe qualifying Plate_in.
- Prog_en  in  1  whitelist write strobe.
- Prog_addr  in  log2(N_ENTRIES)  entry index.
- Prog_data  in  24  plate to store; 24'h000000 clears the entry.
- MatrVal  out  1  one-cycle grant strobe.
- Matricula  out  24  last granted plate, held until next grant.
- Q6  out  7  open time for barrier stage, loaded at grant.
- Denied  out  1  one-cycle miss strobe.
- Busy  out  1  high whenever state is not IDLE.
- Overrun  out  1  one-cycle pulse when a Plate_valid is dropped.

## Operation
- Table: N_ENTRIES × {valid, plate[23:0]}. Write with Prog_data≠0 sets valid; Prog_data=0 clears valid. Entry with valid=0 never matches; Plate_in=0 never matches.
- FSM states: IDLE, SEARCH, GRANT, DENY, HOLD.
- IDLE: Plate_valid captures Plate_in into a working register, idx←0, go SEARCH. Prog_en writes table (accepted only in IDLE).
- IDLE, Prog_en and Plate_valid same cycle: write wins, plate dropped, Overrun=1.
- Prog_en outside IDLE: ignored (no write, no Overrun).
- SEARCH: compare entry[idx] with working plate. Hit → GRANT. Miss and idx=N_ENTRIES-1 → DENY. Else idx+1.
- GRANT (1 cycle): MatrVal=1; Matricula←working plate; Q6←OPEN_CYCLES; hold counter←OPEN_CYCLES; go HOLD.
- DENY (1 cycle): Denied=1; go IDLE. Matricula/Q6 unchanged.
- HOLD: decrement counter each cycle; when it reaches 0 go IDLE (HOLD lasts OPEN_CYCLES cycles).
- Plate_valid in any state but IDLE: dropped, Overrun=1.
- Outputs MatrVal, Denied, Overrun, Busy are registered.

## Timing
- Plate_valid at cycle t (IDLE): SEARCH from t+1; entry k compared at t+1+k.
- Hit at entry k: MatrVal=1 at cycle t+2+k; Matricula/Q6 valid the same cycle.
- No hit: Denied=1 at cycle t+1+N_ENTRIES; IDLE at t+2+N_ENTRIES.
- After grant at cycle g: HOLD g+1..g+OPEN_CYCLES, IDLE at g+OPEN_CYCLES+1.
- Busy=1 from t+1 through last HOLD/DENY cycle.
- Table write at cycle w visible to searches starting at w+1.
- Reset values: MatrVal=0, Denied=0, Overrun=0, Busy=0, Matricula=24'h0, Q6=7'd0, state IDLE, all entries invalid, hold counter 0. RST mid-search/mid-hold aborts immediately with no strobe emitted.

## Configuration
- MATR_ANTIPASSBACK_EN defined: block stores last granted plate (cleared by RST). A search that hits on a plate equal to the stored one goes to DENY instead of GRANT; any different plate granted replaces the stored value. Undefined: logic absent, every hit grants.

## Test plan
- Reset, write 24'hABC123 at idx 3, Plate_valid with 24'hABC123 at t → MatrVal=1 at t+5, Matricula=24'hABC123, Q6=20, Busy low at t+26.
- Empty table, Plate_valid 24'h111111 at t → Denied=1 at t+9, no MatrVal, Busy low at t+10.
- Plate_valid during HOLD → Overrun=1 next cycle, no second MatrVal; Prog_en during HOLD → entry unchanged.
- Prog_en and Plate_valid same IDLE cycle → entry written, Overrun=1, no search; write 24'h0 to hit entry → later search Denied.
- With MATR_ANTIPASSBACK_EN: grant 24'hABC123, repeat after HOLD → Denied; grant 24'h222222, then 24'hABC123 → MatrVal. Without macro: repeat → MatrVal.
- RST asserted in SEARCH and in HOLD → next cycle all outputs at reset values, table cleared, no strobe.
